// File: rtl/irr_param_sync.sv
// Parametrised, clocked Interrupt Request Register for the 8259A datapath.
// Each IR line is synchronised, then latched per channel as edge- or
// level-triggered. Edge channels flag an overrun when a new edge arrives
// while the request is still pending. A fixed-priority encoder (IR0 highest)
// feeds the priority resolver.
module irr_param_sync #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] sensitivityMode,
  input  logic [NUM_IRQ-1:0] peripheralInterrupts,
  input  logic [NUM_IRQ-1:0] clearInterruptRequest,
  input  logic [NUM_IRQ-1:0] clearOverrun,
  output logic [NUM_IRQ-1:0] interruptRequest,
  output logic [NUM_IRQ-1:0] overrun,
  output logic               anyRequest,
  output logic [IDX_W-1:0]   highestRequest
);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] synced;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] irr_q;
  logic [NUM_IRQ-1:0] ovr_q;
  logic [NUM_IRQ-1:0] level_next;
  logic [NUM_IRQ-1:0] edge_next;
  logic [NUM_IRQ-1:0] irr_next;
  logic [NUM_IRQ-1:0] ovr_set;
  logic [NUM_IRQ-1:0] ovr_next;

  // Synchroniser chain: stage 0 samples the raw lines, last stage is 'synced'.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= peripheralInterrupts;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Edge history is tracked in both modes so a mode switch never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
    end else begin
      prev <= synced;
    end
  end

  assign rise = synced & ~prev;

  // A new edge beats a coincident clear; a level request only drops for the
  // single cycle its clear is asserted and comes back while the line is high.
  assign level_next = synced & ~clearInterruptRequest;
  assign edge_next  = rise | (irr_q & ~clearInterruptRequest);
  assign irr_next   = (sensitivityMode & level_next) | (~sensitivityMode & edge_next);

  // Overrun only arises on edge channels; setting beats clearing, and a
  // level channel keeps an old flag until software clears it.
  assign ovr_set  = ~sensitivityMode & rise & irr_q & ~clearInterruptRequest;
  assign ovr_next = ovr_set | (ovr_q & ~clearOverrun);

  // Request and overrun state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irr_q <= '0;
      ovr_q <= '0;
    end else begin
      irr_q <= irr_next;
      ovr_q <= ovr_next;
    end
  end

  assign interruptRequest = irr_q;
  assign overrun          = ovr_q;
  assign anyRequest       = |irr_q;

  // Fixed priority: scan downwards so the lowest set index is the one left.
  always_comb begin
    highestRequest = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irr_q[i]) begin
        highestRequest = IDX_W'(i);
      end
    end
  end

endmodule

// File: doc/irr_param_sync.md
Name: irr_param_sync

Overview:
- Clocked, parametrised Interrupt Request Register for the 8259A PIC datapath.
- Replaces the fixed 8-bit combinational IRR.
- Per-channel edge/level sensitivity, input synchronisers, registered edge detection, per-channel clear, sticky edge-overrun flags, and a fixed-priority request index for the priority resolver.

Parameters:
NUM_IRQ, 8, number of interrupt channels (legal 2..32)
SYNC_STAGES, 2, flip-flop stages on each peripheral input (legal 1..4)
IDX_W, $clog2(NUM_IRQ), width of highestRequest

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
sensitivityMode  input  NUM_IRQ  per channel: 1 = level-triggered, 0 = edge-triggered
peripheralInterrupts  input  NUM_IRQ  raw asynchronous IR lines
clearInterruptRequest  input  NUM_IRQ  per-channel clear pulse from INTA/EOI logic
clearOverrun  input  NUM_IRQ  per-channel clear of overrun flag
interruptRequest  output  NUM_IRQ  registered IRR contents
overrun  output  NUM_IRQ  sticky: edge arrived while IRR bit already set
anyRequest  output  1  OR-reduction of interruptRequest
highestRequest  output  IDX_W  index of lowest-numbered set IRR bit (IR0 highest priority)

Behaviour:
- Reset (async, immediate): sync chain, edge-history register prev, interruptRequest, overrun all 0; anyRequest=0, highestRequest=0.
- Sync: each input passes SYNC_STAGES flops; s = last stage. prev <= s every cycle, regardless of mode.
- rise[i] = s[i] & ~prev[i], combinational, consumed the same cycle.
- Edge channel (mode=0): irr[i] <= rise[i] | (irr[i] & ~clearInterruptRequest[i]).
- Simultaneous rise and clear on an edge channel: bit stays/becomes 1; new edge wins.
- Level channel (mode=1): irr[i] <= s[i] & ~clearInterruptRequest[i].
  - Clear suppresses the bit for one cycle only.
  - Bit reasserts next cycle while the line stays high.
- Overrun, edge channels only: set when rise[i] & irr[i] & ~clearInterruptRequest[i].
  - Cleared when clearOverrun[i] is high and no set condition exists that cycle; set wins.
  - Level channels never set overrun, but retain an existing flag until it is cleared.
- Mode switch: takes effect the same cycle; the new formula is applied to current state.
  - Level->edge with line held high: no edge is generated (prev already 1); the bit holds its value until cleared.
- Latency, input to interruptRequest:
  - Input change settling before rising edge k: irr updates at edge k+SYNC_STAGES.
  - Default: 3rd rising edge after the change.
  - Clear to irr: 1 cycle.
- anyRequest and highestRequest: combinational from registered interruptRequest, no further latency.
  - highestRequest = 0 when anyRequest = 0.
- Reset mid-operation: all state cleared immediately.
  - After release, an input held high produces a rise once through the sync chain and latches on edge channels; this is intended power-up behaviour.
- Channels are fully independent; no arithmetic beyond the priority encode.

Test Plan:
- Edge latch: NUM_IRQ=8, mode=0x00, IR3 0->1 held; clear=0 -> interruptRequest=0x08 at 3rd edge, highestRequest=3; clear[3] pulse -> 0x00 next cycle, stays 0 while IR3 held high.
- Level follow: mode=0xFF, IR5 high -> interruptRequest=0x20 at 3rd edge; clear[5] one cycle -> 0x00 for one cycle, then 0x20 again; IR5 low -> 0x00 three edges later.
- Overrun and simultaneous events:
  - IR1 edge, release, second edge before clear -> overrun=0x02, irr=0x02.
  - Third edge coincident with clear[1] -> irr stays 0x02, overrun stays 0x02.
  - clearOverrun[1] -> overrun=0x00.
- Priority: edges on IR7, IR2, IR6 together -> interruptRequest=0xC4, highestRequest=2, anyRequest=1; clear[2] -> highestRequest=6.
- Async reset: assert reset mid-cycle with irr=0xFF, overrun=0x10 -> all outputs 0 immediately, before next edge; release with IR0 high, mode=0 -> irr=0x01 three edges later.
- Mode switch: IR4 high in level mode (irr=0x10); switch to edge -> bit holds 0x10, no overrun; clear[4] -> 0x00 and stays 0 while IR4 high.
